// File: rtl/dsec_rx_ctrl.sv
// dsec_rx_ctrl -- receive-side controller for the encrypted word stream.
//
// Loads three 64-bit keys, forwards ciphertext to an external combinational
// Triple-DES decryption core and buffers the returned plaintext in a 2-entry
// output queue with a valid/received handshake. Protocol errors are reported
// in-band on data_out while error is high.
//
// Optional feature: define DSEC_RX_KEYCHK_EN to check every key beat for odd
// parity in each byte. A key that fails the check is still stored, and the
// block enters the error state with error 8'h03.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   data_in     key word or ciphertext word
//   key_config  marks the current beat as key 1 of a key load
//   in_valid    data_in valid; a beat transfers on in_valid && rdy
//   out_rcvd    downstream takes data_out on out_valid && out_rcvd
//   dec_out     plaintext from the external decryption core
//   rdy         block can accept a beat
//   data_out    head of the output queue, or the error code in ERR
//   out_valid   data_out is valid
//   error       block is in the error state
//   dec_in      ciphertext to the decryption core (equals data_in)
//   key_1..3    registered keys to the decryption core
module dsec_rx_ctrl #(
  parameter logic [63:0] ERR_BASE = 64'hDEAD_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        key_config,
  input  logic        in_valid,
  input  logic        out_rcvd,
  input  logic [63:0] dec_out,
  output logic        rdy,
  output logic [63:0] data_out,
  output logic        out_valid,
  output logic        error,
  output logic [63:0] dec_in,
  output logic [63:0] key_1,
  output logic [63:0] key_2,
  output logic [63:0] key_3
);

  typedef enum logic [2:0] {
    S_NOKEY,
    S_KEY2,
    S_KEY3,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [7:0] ERR_NO_KEY  = 8'h01;
  localparam logic [7:0] ERR_KEY_PAR = 8'h03;

  state_t      state_q, state_d;
  logic [63:0] key_1_q, key_1_d;
  logic [63:0] key_2_q, key_2_d;
  logic [63:0] key_3_q, key_3_d;
  logic [63:0] q0_q, q0_d;          // queue head
  logic [63:0] q1_q, q1_d;          // second entry
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_num_q, err_num_d;

  logic xfer, pop, key_beat, key_bad;

  // Byte-wise odd parity check of the incoming key word.
`ifdef DSEC_RX_KEYCHK_EN
  always_comb begin
    key_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^data_in[8*b +: 8])) key_bad = 1'b1;
    end
  end
`else
  assign key_bad = 1'b0;
`endif

  // Outputs
  assign error     = (state_q == S_ERR);
  assign out_valid = error || (count_q != 2'd0);
  assign data_out  = error ? (ERR_BASE | {56'd0, err_num_q}) : q0_q;
  assign rdy       = (state_q != S_RUN) || (count_q != 2'd2);
  assign dec_in    = data_in;
  assign key_1     = key_1_q;
  assign key_2     = key_2_q;
  assign key_3     = key_3_q;

  assign xfer = in_valid && rdy;
  assign pop  = out_valid && out_rcvd && !error;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    key_1_d   = key_1_q;
    key_2_d   = key_2_q;
    key_3_d   = key_3_q;
    q0_d      = q0_q;
    q1_d      = q1_q;
    count_d   = count_q;
    err_num_d = err_num_q;
    key_beat  = 1'b0;

    // Pop first; a push in the same cycle then lands behind the survivor.
    if (pop) begin
      q0_d    = q1_q;
      count_d = count_q - 2'd1;
    end

    if (xfer) begin
      unique case (state_q)
        S_NOKEY, S_RUN, S_ERR: begin
          if (key_config) begin
            key_1_d  = data_in;
            count_d  = 2'd0;
            state_d  = S_KEY2;
            key_beat = 1'b1;
          end else if (state_q == S_NOKEY) begin
            state_d   = S_ERR;
            err_num_d = ERR_NO_KEY;
            count_d   = 2'd0;
          end else if (state_q == S_RUN) begin
            // rdy guarantees at most one entry is left after the pop.
            if (count_d == 2'd0) q0_d = dec_out;
            else                 q1_d = dec_out;
            count_d = count_d + 2'd1;
          end
        end
        S_KEY2: begin
          key_2_d  = data_in;
          state_d  = S_KEY3;
          key_beat = 1'b1;
        end
        S_KEY3: begin
          key_3_d  = data_in;
          state_d  = S_RUN;
          key_beat = 1'b1;
        end
        default: state_d = S_NOKEY;
      endcase
    end

    // A key with bad parity is kept but diverts the load into ERR.
    if (key_beat && key_bad) begin
      state_d   = S_ERR;
      err_num_d = ERR_KEY_PAR;
      count_d   = 2'd0;
    end
  end

  // NOTE: queue storage is reset along with the control state because the
  // head entry drives data_out, which must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_NOKEY;
      key_1_q   <= '0;
      key_2_q   <= '0;
      key_3_q   <= '0;
      q0_q      <= '0;
      q1_q      <= '0;
      count_q   <= 2'd0;
      err_num_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above.
      state_q   <= state_d;
      key_1_q   <= key_1_d;
      key_2_q   <= key_2_d;
      key_3_q   <= key_3_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      err_num_q <= err_num_d;
    end
  end

endmodule

// File: tb/tb_dsec_rx_ctrl.sv
// Testbench for dsec_rx_ctrl: directed key loads, data words, backpressure,
// error handling and mid-load reset, checked every cycle against a
// transaction-level model, plus hand-computed literal expectations.
// The external decryption core is stood in for by dec_out = dec_in ^ key_1.
module tb_dsec_rx_ctrl;

  localparam logic [63:0] ERR_BASE = 64'hDEAD_0000_0000_0000;
  localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K2 = 64'h2345_6789_ABCD_EF01;
  localparam logic [63:0] K3 = 64'h4567_89AB_CDEF_0123;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0;
  logic        key_config = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_rcvd = 1'b0;
  logic [63:0] dec_out;
  logic        rdy, out_valid, error;
  logic [63:0] data_out, dec_in, key_1, key_2, key_3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in decryption core, combinational from dec_in.
  assign dec_out = dec_in ^ key_1;

  dsec_rx_ctrl #(.ERR_BASE(ERR_BASE)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .key_config(key_config),
    .in_valid(in_valid), .out_rcvd(out_rcvd), .dec_out(dec_out),
    .rdy(rdy), .data_out(data_out), .out_valid(out_valid), .error(error),
    .dec_in(dec_in), .key_1(key_1), .key_2(key_2), .key_3(key_3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_key [3];
  logic [63:0] m_q [$];
  int          m_have;   // keys captured in the current load (3 = running)
  bit          m_err;
  logic [7:0]  m_num;

  function automatic bit m_rdy();
    return m_err || (m_have < 3) || (m_q.size() < 2);
  endfunction

  function automatic bit m_key_bad(input logic [63:0] k);
    bit bad = 1'b0;
`ifdef DSEC_RX_KEYCHK_EN
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) bad = 1'b1;
`else
    bad = (k === 64'hx);  // parity ignored
`endif
    return bad;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_key[i] = '0;
    m_q.delete();
    m_have = 0;
    m_err  = 1'b0;
    m_num  = 8'd0;
  endtask

  task automatic m_step();
    bit xfer;
    int slot;
    xfer = in_valid && m_rdy();
    if (!m_err && out_rcvd && m_q.size() > 0) void'(m_q.pop_front());
    if (!xfer) return;
    slot = -1;
    if (key_config && (m_have == 0 || m_have == 3 || m_err)) slot = 0;
    else if (m_err) slot = -1;                       // data beat in ERR: ignored
    else if (m_have == 1 || m_have == 2) slot = m_have;
    else if (m_have == 3) m_q.push_back(data_in ^ m_key[0]);
    else begin
      m_err = 1'b1; m_num = 8'h01; m_q.delete();
    end
    if (slot >= 0) begin
      m_key[slot] = data_in;
      if (slot == 0) m_q.delete();
      if (m_key_bad(data_in)) begin
        m_err = 1'b1; m_num = 8'h03; m_have = 0; m_q.delete();
      end else begin
        m_err  = 1'b0;
        m_have = slot + 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if ($time > 2) begin
      check("rdy", {63'd0, rdy}, {63'd0, m_rdy()});
      check("error", {63'd0, error}, {63'd0, m_err});
      check("out_valid", {63'd0, out_valid}, {63'd0, (m_err || m_q.size() > 0)});
      check("key_1", key_1, m_key[0]);
      check("key_2", key_2, m_key[1]);
      check("key_3", key_3, m_key[2]);
      if (m_err)             check("data_out_err", data_out, ERR_BASE | {56'd0, m_num});
      else if (m_q.size() > 0) check("data_out", data_out, m_q[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [63:0] d, input logic kc);
    bit r, done;
    data_in = d; key_config = kc; in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      r = rdy;
      @(posedge clk);
      #2;
      if (r) done = 1'b1;
    end
    in_valid = 1'b0; key_config = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %h never transferred, expected transfer within 20 cycles", d);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;

  initial begin
    m_reset();
    #1 rst = 1'b0;
    tick(2);
    check("reset_rdy", {63'd0, rdy}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_error", {63'd0, error}, 64'd0);
    check("reset_data_out", data_out, 64'd0);
    check("reset_key_1", key_1, 64'd0);
    rst = 1'b1;
    tick(1);

    // Key load (key_config on key 2 is ignored), then first word at once.
    send(K1, 1'b1);
    send(K2, 1'b1);
    send(K3, 1'b0);
    send(W1, 1'b0);
    check("load_key_1", key_1, K1);
    check("load_key_2", key_2, K2);
    check("load_key_3", key_3, K3);
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_word", data_out, 64'h1032_5476_98BA_DCFE);
    out_rcvd = 1'b1; tick(1); out_rcvd = 1'b0;
    check("first_popped", {63'd0, out_valid}, 64'd0);

    // Backpressure: two words fill the queue, third waits for a pop.
    send(W2, 1'b0);
    check("one_entry_rdy", {63'd0, rdy}, 64'd1);
    send(W3, 1'b0);
    check("full_rdy", {63'd0, rdy}, 64'd0);
    data_in = W4; in_valid = 1'b1;
    tick(3);
    check("held_head", data_out, W2 ^ K1);
    out_rcvd = 1'b1; tick(1); out_rcvd = 1'b0;
    check("rdy_after_pop", {63'd0, rdy}, 64'd1);
    check("head_after_pop", data_out, W3 ^ K1);
    tick(1); in_valid = 1'b0;
    out_rcvd = 1'b1; tick(1);
    check("order_w4", data_out, W4 ^ K1);
    tick(1); out_rcvd = 1'b0;
    check("drained", {63'd0, out_valid}, 64'd0);

    // Same-cycle push and pop at count 1.
    send(W1, 1'b0);
    data_in = W2; in_valid = 1'b1; out_rcvd = 1'b1;
    tick(1);
    in_valid = 1'b0; out_rcvd = 1'b0;
    check("pp_valid", {63'd0, out_valid}, 64'd1);
    check("pp_word", data_out, W2 ^ K1);
    out_rcvd = 1'b1; tick(1); out_rcvd = 1'b0;
    check("pp_count_one", {63'd0, out_valid}, 64'd0);

    // Data before keys.
    do_reset();
    send(W3, 1'b0);
    check("nokey_error", {63'd0, error}, 64'd1);
    check("nokey_code", data_out, 64'hDEAD_0000_0000_0001);
    out_rcvd = 1'b1; send(W4, 1'b0); out_rcvd = 1'b0;
    check("err_sticky", data_out, 64'hDEAD_0000_0000_0001);
    send(K1, 1'b1);
    check("err_cleared", {63'd0, error}, 64'd0);
    check("err_new_key_1", key_1, K1);

    // Reset between key 2 and key 3.
    send(K2, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("midload_key_1", key_1, 64'd0);
    check("midload_key_2", key_2, 64'd0);
    check("midload_rdy", {63'd0, rdy}, 64'd1);
    tick(1);
    rst = 1'b1;
    tick(1);

    // All-zero key 1: parity failure only when the check is built in.
    send(64'd0, 1'b1);
`ifdef DSEC_RX_KEYCHK_EN
    check("par_error", {63'd0, error}, 64'd1);
    check("par_code", data_out, 64'hDEAD_0000_0000_0003);
`else
    check("nopar_error", {63'd0, error}, 64'd0);
    send(K2, 1'b0);
    check("nopar_key_2", key_2, K2);
`endif
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
